// File: rtl/serial_subtractor_16bit.sv
// rtl/serial_subtractor_16bit.sv - bit-serial unsigned subtractor with start/busy/done handshake
//
// Computes difference = a - b - borrow_in (mod 2^NUM_BITS), one bit per clock,
// LSB first, and reports the final borrow out of the MSB as underflow.
//
// Ports:
//   clk        system clock, all state changes on rising edge
//   rst        synchronous active-high reset, priority over start
//   start      request to begin; accepted in IDLE or DONE
//   a, b       minuend / subtrahend, sampled only on the accepting edge
//   borrow_in  initial borrow, sampled only on the accepting edge
//   busy       high while bits are being processed
//   done       high while difference/underflow hold a valid result
//   difference result register (partial while busy)
//   underflow  borrow out of bit NUM_BITS-1 (1 iff a < b + borrow_in)

module serial_subtractor_16bit #(
  parameter int NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] difference,
  output logic                underflow
);

  localparam int CW = $clog2(NUM_BITS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  logic [1:0]          state;
  logic [NUM_BITS-1:0] a_sh;
  logic [NUM_BITS-1:0] b_sh;
  logic                br;
  logic [CW-1:0]       cnt;

  logic a_i;
  logic b_i;
  logic d_i;
  logic br_next;

  // Full-subtractor cell for the bit currently at the bottom of the operand shifters.
  assign a_i     = a_sh[0];
  assign b_i     = b_sh[0];
  assign d_i     = a_i ^ b_i ^ br;
  assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      difference <= '0;
      underflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh       <= a;
            b_sh       <= b;
            br         <= borrow_in;
            cnt        <= '0;
            difference <= '0;
            underflow  <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          // New bit enters at the MSB so the result is right-aligned after NUM_BITS shifts.
          difference <= {d_i, difference[NUM_BITS-1:1]};
          a_sh       <= {1'b0, a_sh[NUM_BITS-1:1]};
          b_sh       <= {1'b0, b_sh[NUM_BITS-1:1]};
          br         <= br_next;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST) begin
            underflow <= br_next;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// tb/tb_serial_subtractor_16bit.sv - directed self-checking bench for serial_subtractor_16bit

module tb_serial_subtractor_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        borrow_in;
  logic        busy;
  logic        done;
  logic [15:0] difference;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  serial_subtractor_16bit #(.NUM_BITS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts rising edges until done is seen (sampled #1 after each edge), bounded.
  task automatic wait_done(input int already, output int n);
    n = already;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Accepts one operation and checks latency and result against hand-computed values.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic bin, input logic [15:0] exp_d, input logic exp_u);
    int n;
    @(negedge clk);
    a = av; b = bv; borrow_in = bin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; borrow_in = 1'b1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(0, n);
    check({tag, "_lat"}, n, 16);
    check({tag, "_diff"}, 32'(difference), 32'(exp_d));
    check({tag, "_uf"}, 32'(underflow), 32'(exp_u));
  endtask

  initial begin
    int n;
    logic [15:0] ca, cb;
    logic        cbin;
    logic [16:0] ref_v;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(difference), 0);
    check("rst_uf", 32'(underflow), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("zero_busy_after", 32'(busy), 0);
    run_op("ffff_f", 16'hFFFF, 16'h000F, 1'b0, 16'hFFF0, 1'b0);
    run_op("f_ffff", 16'h000F, 16'hFFFF, 1'b0, 16'h0010, 1'b1);
    run_op("bin_eq", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
    run_op("msb_bin", 16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0);
    run_op("zero_m1", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);

    // start during RUN must be ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy", 32'(busy), 1);
    wait_done(5, n);
    check("ign_lat", n, 16);
    check("ign_diff", 32'(difference), 32'h1000);
    check("ign_uf", 32'(underflow), 0);

    // reset in the middle of an operation
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F00; borrow_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_diff", 32'(difference), 0);
    check("mrst_uf", 32'(underflow), 0);
    run_op("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0);

    // start held high from DONE: one result every 17 cycles
    @(negedge clk);
    ca = 16'($urandom); cb = 16'($urandom); cbin = 1'($urandom);
    a = ca; b = cb; borrow_in = cbin; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      ref_v = {1'b0, ca} - {1'b0, cb} - {16'b0, cbin};
      check("b2b_busy", 32'(busy), 1);
      ca = 16'($urandom); cb = 16'($urandom); cbin = 1'($urandom);
      if (k == 1) begin ca = 16'h0005; cb = 16'h0005; cbin = 1'b1; end
      a = ca; b = cb; borrow_in = cbin;
      wait_done(0, n);
      check("b2b_lat", n, 16);
      check("b2b_diff", 32'(difference), 32'(ref_v[15:0]));
      check("b2b_uf", 32'(underflow), 32'(ref_v[16]));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done_hold", 32'(done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_16bit.md
Name: serial_subtractor_16bit

Overview:
- Bit-serial unsigned subtractor: computes difference = a - b - borrow_in, one bit per clock, LSB first.
- Reports underflow, the borrow out of the MSB.
- It is the inverse-direction companion to the combinational 16-bit adder.
- Shares that adder's operand/result widths and its result/flag pairing (sum/overflow becomes difference/underflow).
- Wrapped in a start/busy/done handshake for use by sequential datapaths and controllers.

Parameters:
- NUM_BITS, 16, operand and difference width; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin; sampled on rising edge of clk.
- a  input  NUM_BITS  minuend; sampled only on the accepting edge.
- b  input  NUM_BITS  subtrahend; sampled only on the accepting edge.
- borrow_in  input  1  initial borrow; sampled only on the accepting edge.
- busy  output  1  high while the subtraction is in progress.
- done  output  1  high while difference/underflow hold a valid result.
- difference  output  NUM_BITS  a - b - borrow_in, modulo 2^NUM_BITS.
- underflow  output  1  final borrow out of bit NUM_BITS-1 (1 iff a < b + borrow_in, unsigned).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high; no asynchronous logic.
- Reset (rst=1 at a rising edge, regardless of state):
  - state <= IDLE; busy=0, done=0, difference=0, underflow=0.
  - Internal operand, borrow and bit-counter registers cleared.
  - rst has priority over start.
- States: IDLE, RUN, DONE. Encoding is implementer's choice.
- IDLE: busy=0, done=0.
  - start=1 -> latch a, b, borrow_in into internal shift/borrow registers; clear bit counter; clear difference register; go to RUN.
- RUN: busy=1, done=0. Each edge:
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i is shifted into the MSB of the difference register (result is right-aligned after NUM_BITS shifts); operand registers shift right; counter++.
  - On the edge that processes bit NUM_BITS-1: underflow <= br_next; go to DONE.
- DONE: busy=0, done=1; difference and underflow hold until the next accepted start or reset.
  - start=1 -> accept new operands exactly as from IDLE; done falls on that same edge.
- start while in RUN: ignored; no effect on the operation in flight; not queued.
- Latency: start accepted at edge E0 -> done=1 and result valid after edge E(NUM_BITS), i.e. 16 cycles for the default.
  - Back-to-back operations: throughput one result per NUM_BITS+1 cycles.
- The difference/underflow outputs present registered state only.
  - During RUN they may show partial values; they are valid only while done=1.
- Operand inputs may change freely after the accepting edge without affecting the result.
- Reset mid-operation: the in-flight result is discarded; the next start after reset behaves as from a clean power-up.
- Wrap-around:
  - 0 - 1 gives all ones with underflow=1.
  - borrow_in=1 with a=b gives all ones with underflow=1.
- Counter width: $clog2(NUM_BITS).
- No X propagation from unsampled inputs: a, b and borrow_in are don't-care outside the accepting edge.

Test Plan:
- Reset, then a=16'h0000, b=16'h0000, borrow_in=0, start pulse -> busy=1 for 16 cycles; then done=1, difference=16'h0000, underflow=0.
- a=16'hFFFF, b=16'h000F, borrow_in=0 -> difference=16'hFFF0, underflow=0. Then a=16'h000F, b=16'hFFFF -> difference=16'h0010, underflow=1.
- a=16'h0000, b=16'h0000, borrow_in=1 -> difference=16'hFFFF, underflow=1. Then a=16'h8000, b=16'h0001, borrow_in=1 -> difference=16'h7FFE, underflow=0.
- Start a=16'h1234, b=16'h0234; at cycle 5 of RUN pulse start with a=16'hFFFF, b=16'h0000 and change the operand inputs -> start ignored; after 16 cycles difference=16'h1000, underflow=0.
- Start an operation; assert rst at cycle 8 of RUN -> next edge busy=0, done=0, difference=0, underflow=0. A fresh start of a=16'h0010, b=16'h0001 -> difference=16'h000F, underflow=0 after 16 cycles.
- From DONE, hold start=1 continuously with a randomized operand set each accept (a, b, borrow_in) -> a result every 17 cycles, each matching the reference model (a - b - borrow_in) & 16'hFFFF, underflow = (a < b + borrow_in).
